io_pad_pwr_seq: RTL and testbench

- Sequences the IO ring pad control signals (retention/isolation, input enable, output enable) against the IO supply (VDDQ/VSSQ) and core supply (VDD/VSS) good indications.
- Sits between the analog supply comparators and the IO pad cells of the EG1D80V ring.
- Guarantees pads leave retention only after both supplies are stable, and re-enter retention immediately on supply loss.
- Single clock domain; the supply-good inputs are asynchronous and synchronised internally.

---
 rtl/io_pad_pwr_seq.sv | 174 +++++++++++++++++
 tb/tb_io_pad_pwr_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_pad_pwr_seq.sv
// IO ring pad power sequencer: walks pads out of retention once VDDQ and VDD are
// stable, steps input/output enables up and down, and falls back to retention on supply loss.
module io_pad_pwr_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 64,
  parameter int STEP_CYC    = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vddq_good_a,
  input  logic       vdd_good_a,
  input  logic       seq_start,
  input  logic       seq_stop,
  input  logic       fault_clr,
  output logic       pad_ret,
  output logic       pad_ie,
  output logic       pad_oe,
  output logic       seq_done,
  output logic       fault,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    ST_OFF    = 4'd0,
    ST_WAIT   = 4'd1,
    ST_SETTLE = 4'd2,
    ST_REL    = 4'd3,
    ST_IE     = 4'd4,
    ST_ON     = 4'd5,
    ST_PD_OE  = 4'd6,
    ST_PD_IE  = 4'd7,
    ST_FAULT  = 4'd8
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LD    = CNT_W'(STEP_CYC - 1);

  // Output vector order: {ret, ie, oe, done, fault}
  function automatic logic [4:0] decode_outputs(input state_e st);
    case (st)
      ST_OFF:    decode_outputs = 5'b10000;
      ST_WAIT:   decode_outputs = 5'b10000;
      ST_SETTLE: decode_outputs = 5'b10000;
      ST_REL:    decode_outputs = 5'b00000;
      ST_IE:     decode_outputs = 5'b01000;
      ST_ON:     decode_outputs = 5'b01110;
      ST_PD_OE:  decode_outputs = 5'b01000;
      ST_PD_IE:  decode_outputs = 5'b00000;
      ST_FAULT:  decode_outputs = 5'b10001;
      default:   decode_outputs = 5'b10000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dwell_load(input state_e st);
    case (st)
      ST_WAIT:   dwell_load = TIMEOUT_LD;
      ST_SETTLE: dwell_load = SETTLE_LD;
      ST_REL:    dwell_load = STEP_LD;
      ST_IE:     dwell_load = STEP_LD;
      ST_PD_OE:  dwell_load = STEP_LD;
      ST_PD_IE:  dwell_load = STEP_LD;
      default:   dwell_load = CNT_ZERO;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] vddq_sync_q;
  logic [SYNC_STAGES-1:0] vdd_sync_q;
  logic                   sup_ok;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [4:0]             out_q, out_d;
  logic                   cnt_zero;

  // Synchronisers carry no reset so supply status is valid straight out of reset
  always_ff @(posedge clk) begin
    vddq_sync_q <= {vddq_sync_q[SYNC_STAGES-2:0], vddq_good_a};
    vdd_sync_q  <= {vdd_sync_q[SYNC_STAGES-2:0], vdd_good_a};
  end

  assign sup_ok   = vddq_sync_q[SYNC_STAGES-1] & vdd_sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_q == CNT_ZERO);

  // Next-state: supply loss outranks stop and dwell expiry once retention is released
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (seq_start) state_d = ST_WAIT;
        else           state_d = ST_OFF;
      end
      ST_WAIT: begin
        if (seq_stop)      state_d = ST_OFF;
        else if (sup_ok)   state_d = ST_SETTLE;
        else if (cnt_zero) state_d = ST_FAULT;
        else               state_d = ST_WAIT;
      end
      ST_SETTLE: begin
        if (seq_stop)      state_d = ST_OFF;
        else if (!sup_ok)  state_d = ST_WAIT;
        else if (cnt_zero) state_d = ST_REL;
        else               state_d = ST_SETTLE;
      end
      ST_REL: begin
        if (!sup_ok)       state_d = ST_FAULT;
        else if (cnt_zero) state_d = ST_IE;
        else               state_d = ST_REL;
      end
      ST_IE: begin
        if (!sup_ok)       state_d = ST_FAULT;
        else if (cnt_zero) state_d = ST_ON;
        else               state_d = ST_IE;
      end
      ST_ON: begin
        if (!sup_ok)       state_d = ST_FAULT;
        else if (seq_stop) state_d = ST_PD_OE;
        else               state_d = ST_ON;
      end
      ST_PD_OE: begin
        if (!sup_ok)       state_d = ST_FAULT;
        else if (cnt_zero) state_d = ST_PD_IE;
        else               state_d = ST_PD_OE;
      end
      ST_PD_IE: begin
        if (!sup_ok)       state_d = ST_FAULT;
        else if (cnt_zero) state_d = ST_OFF;
        else               state_d = ST_PD_IE;
      end
      ST_FAULT: begin
        if (fault_clr) state_d = ST_OFF;
        else           state_d = ST_FAULT;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Dwell counter reloads on every state entry, so SETTLE->WAIT restarts the timeout
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = dwell_load(state_d);
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    out_d = decode_outputs(state_d);
  end

  // State, counter and decoded pad controls all update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= CNT_ZERO;
      out_q   <= 5'b10000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign pad_ret  = out_q[4];
  assign pad_ie   = out_q[3];
  assign pad_oe   = out_q[2];
  assign seq_done = out_q[1];
  assign fault    = out_q[0];
  assign state_o  = state_q;

endmodule

// File: tb/tb_io_pad_pwr_seq.sv
// Directed bench for io_pad_pwr_seq with short dwell parameters and hand-derived
// per-cycle state sequences.
module tb_io_pad_pwr_seq;

  localparam logic [3:0] S_OFF = 4'd0, S_WAIT = 4'd1, S_SETTLE = 4'd2, S_REL = 4'd3,
                         S_IE = 4'd4, S_ON = 4'd5, S_PD_OE = 4'd6, S_PD_IE = 4'd7,
                         S_FAULT = 4'd8;

  logic       clk = 1'b0;
  logic       rst, vddq_good_a, vdd_good_a, seq_start, seq_stop, fault_clr;
  logic       pad_ret, pad_ie, pad_oe, seq_done, fault;
  logic [3:0] state_o;
  logic [3:0] prev_st;
  int         checks = 0;
  int         errors = 0;

  io_pad_pwr_seq #(
    .SYNC_STAGES(2), .SETTLE_CYC(4), .STEP_CYC(2), .TIMEOUT_CYC(16), .CNT_W(13)
  ) dut (
    .clk(clk), .rst(rst), .vddq_good_a(vddq_good_a), .vdd_good_a(vdd_good_a),
    .seq_start(seq_start), .seq_stop(seq_stop), .fault_clr(fault_clr),
    .pad_ret(pad_ret), .pad_ie(pad_ie), .pad_oe(pad_oe), .seq_done(seq_done),
    .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected {ret, ie, oe, done, fault} for each state
  function automatic logic [4:0] exp_out(input logic [3:0] s);
    case (s)
      S_REL:   return 5'b00000;
      S_IE:    return 5'b01000;
      S_ON:    return 5'b01110;
      S_PD_OE: return 5'b01000;
      S_PD_IE: return 5'b00000;
      S_FAULT: return 5'b10001;
      default: return 5'b10000;
    endcase
  endfunction

  // One clock edge; outputs are sampled 1 time unit later and the pad invariants checked
  task automatic tick();
    prev_st = state_o;
    @(posedge clk);
    #1;
    checks++;
    if (pad_oe && (!pad_ie || pad_ret)) begin
      errors++;
      $display("FAIL inv_oe: oe=%b ie=%b ret=%b, required oe=1 only with ie=1 ret=0", pad_oe, pad_ie, pad_ret);
    end
    checks++;
    if (!pad_ret && (prev_st == S_OFF || prev_st == S_WAIT || prev_st == S_FAULT)) begin
      errors++;
      $display("FAIL inv_ret: ret=0 after state %0d, required previous state not OFF/WAIT/FAULT", prev_st);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vddq_good_a = 1'b1; vdd_good_a = 1'b1;
    seq_start = 1'b0; seq_stop = 1'b0; fault_clr = 1'b0;
    prev_st = S_OFF;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (state_o !== S_OFF || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== 5'b10000) begin
      errors++;
      $display("FAIL reset: state %0d out %b, required state 0 out 10000", state_o, {pad_ret, pad_ie, pad_oe, seq_done, fault});
    end
  endtask

  task automatic test_power_up();
    logic [3:0] exp_s [11];
    exp_s = '{S_WAIT, S_SETTLE, S_SETTLE, S_SETTLE, S_SETTLE, S_REL, S_REL, S_IE, S_IE, S_ON, S_ON};
    rst = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k == 0) seq_start = 1'b1;
      if (k == 1) seq_start = 1'b0;
      tick();
      checks++;
      if (state_o !== exp_s[k] || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== exp_out(exp_s[k])) begin
        errors++;
        $display("FAIL power_up cyc %0d: state %0d out %b, required state %0d out %b", k, state_o,
                 {pad_ret, pad_ie, pad_oe, seq_done, fault}, exp_s[k], exp_out(exp_s[k]));
      end
    end
  endtask

  task automatic test_power_down();
    logic [3:0] exp_s [6];
    exp_s = '{S_PD_OE, S_PD_OE, S_PD_IE, S_PD_IE, S_OFF, S_OFF};
    for (int k = 0; k < 6; k++) begin
      if (k == 0) seq_stop = 1'b1;
      if (k == 5) seq_stop = 1'b0;
      tick();
      checks++;
      if (state_o !== exp_s[k] || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== exp_out(exp_s[k])) begin
        errors++;
        $display("FAIL power_down cyc %0d: state %0d out %b, required state %0d out %b", k, state_o,
                 {pad_ret, pad_ie, pad_oe, seq_done, fault}, exp_s[k], exp_out(exp_s[k]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_s [3];
    exp_s = '{S_WAIT, S_OFF, S_OFF};
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin seq_start = 1'b1; seq_stop = 1'b1; end
      if (k == 1) seq_start = 1'b0;
      if (k == 2) seq_stop = 1'b0;
      tick();
      checks++;
      if (state_o !== exp_s[k] || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== exp_out(exp_s[k])) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: state %0d out %b, required state %0d out %b", k, state_o,
                 {pad_ret, pad_ie, pad_oe, seq_done, fault}, exp_s[k], exp_out(exp_s[k]));
      end
    end
  endtask

  // vdd glitch in SETTLE, then a stop request held through REL/IE that acts once ON is reached
  task automatic test_glitch();
    logic [3:0] exp_s [19];
    exp_s = '{S_WAIT, S_SETTLE, S_SETTLE, S_SETTLE, S_WAIT, S_SETTLE, S_SETTLE, S_SETTLE, S_SETTLE,
              S_REL, S_REL, S_IE, S_IE, S_ON, S_PD_OE, S_PD_OE, S_PD_IE, S_PD_IE, S_OFF};
    for (int k = 0; k < 19; k++) begin
      if (k == 0)  seq_start = 1'b1;
      if (k == 1)  seq_start = 1'b0;
      if (k == 2)  vdd_good_a = 1'b0;
      if (k == 3)  vdd_good_a = 1'b1;
      if (k == 10) seq_stop = 1'b1;
      tick();
      checks++;
      if (state_o !== exp_s[k] || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== exp_out(exp_s[k])) begin
        errors++;
        $display("FAIL glitch cyc %0d: state %0d out %b, required state %0d out %b", k, state_o,
                 {pad_ret, pad_ie, pad_oe, seq_done, fault}, exp_s[k], exp_out(exp_s[k]));
      end
    end
    seq_stop = 1'b0;
  endtask

  task automatic test_supply_loss();
    logic [3:0] exp_s [16];
    exp_s = '{S_WAIT, S_SETTLE, S_SETTLE, S_SETTLE, S_SETTLE, S_REL, S_REL, S_IE, S_IE, S_ON,
              S_ON, S_ON, S_FAULT, S_FAULT, S_OFF, S_OFF};
    for (int k = 0; k < 16; k++) begin
      if (k == 0)  seq_start = 1'b1;
      if (k == 1)  seq_start = 1'b0;
      if (k == 10) vddq_good_a = 1'b0;
      if (k == 12) seq_stop = 1'b1;
      if (k == 14) begin seq_stop = 1'b0; fault_clr = 1'b1; end
      if (k == 15) fault_clr = 1'b0;
      tick();
      checks++;
      if (state_o !== exp_s[k] || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== exp_out(exp_s[k])) begin
        errors++;
        $display("FAIL supply_loss cyc %0d: state %0d out %b, required state %0d out %b", k, state_o,
                 {pad_ret, pad_ie, pad_oe, seq_done, fault}, exp_s[k], exp_out(exp_s[k]));
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_s;
    vddq_good_a = 1'b0; vdd_good_a = 1'b0;
    tick(); tick();
    for (int k = 0; k < 19; k++) begin
      if (k == 0)  seq_start = 1'b1;
      if (k == 18) begin seq_start = 1'b0; fault_clr = 1'b1; end
      exp_s = (k < 16) ? S_WAIT : ((k < 18) ? S_FAULT : S_OFF);
      tick();
      checks++;
      if (state_o !== exp_s || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== exp_out(exp_s)) begin
        errors++;
        $display("FAIL timeout cyc %0d: state %0d out %b, required state %0d out %b", k, state_o,
                 {pad_ret, pad_ie, pad_oe, seq_done, fault}, exp_s, exp_out(exp_s));
      end
    end
    fault_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    vddq_good_a = 1'b1; vdd_good_a = 1'b1;
    tick(); tick(); tick();
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (state_o !== S_IE || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_mid_reach_ie: state %0d out %b, required state 4 out 01000", state_o,
               {pad_ret, pad_ie, pad_oe, seq_done, fault});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (state_o !== S_OFF || {pad_ret, pad_ie, pad_oe, seq_done, fault} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid: state %0d out %b, required state 0 out 10000", state_o,
               {pad_ret, pad_ie, pad_oe, seq_done, fault});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state_o !== S_OFF) begin
      errors++;
      $display("FAIL reset_mid_after: state %0d, required state 0", state_o);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_back_to_back();
    test_glitch();
    test_supply_loss();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
